// File: rtl/duty_seq_recorder_if.sv
// duty_seq_recorder_if: control, button and duty bus of the duty record/playback sequencer
// master drives Storage_Sw/Play_En/Loop_En/Bt_*/Duty_In; slave drives DC_Out/Rec_Count/Full/Playing/Done
interface duty_seq_recorder_if #(
  parameter int DW  = 6,
  parameter int NCH = 2,
  parameter int AW  = 8
);
  logic              Storage_Sw;
  logic              Play_En;
  logic              Loop_En;
  logic              Bt_Up;
  logic              Bt_Down;
  logic              Bt_Left;
  logic              Bt_Right;
  logic [NCH*DW-1:0] Duty_In;
  logic [NCH*DW-1:0] DC_Out;
  logic [AW:0]       Rec_Count;
  logic              Full;
  logic              Playing;
  logic              Done;
  modport master (
    output Storage_Sw, Play_En, Loop_En, Bt_Up, Bt_Down, Bt_Left, Bt_Right, Duty_In,
    input  DC_Out, Rec_Count, Full, Playing, Done
  );
  modport slave (
    input  Storage_Sw, Play_En, Loop_En, Bt_Up, Bt_Down, Bt_Left, Bt_Right, Duty_In,
    output DC_Out, Rec_Count, Full, Playing, Done
  );
endinterface

// File: rtl/duty_seq_recorder.sv
// duty_seq_recorder: multi-channel duty-cycle record/playback sequencer
// sysclk: system clock; Reset_Sw: synchronous active-high reset
// bus (slave): Storage_Sw/Play_En/Loop_En mode controls, Bt_* record buttons, Duty_In live vector,
//   DC_Out registered duty, Rec_Count stored vectors, Full, Playing, Done
module duty_seq_recorder #(
  parameter int DW       = 6,
  parameter int NCH      = 2,
  parameter int DEPTH    = 256,
  parameter int AW       = 8,
  parameter int TICK_DIV = 4096
) (
  input logic                 sysclk,
  input logic                 Reset_Sw,
  duty_seq_recorder_if.slave  bus
);
  localparam int TW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, RECORD, PLAY, DONE} state_t;
  state_t            state_q, state_d;
  logic [2:0]        sync_q;
  logic [AW:0]       cnt_q;
  logic [AW-1:0]     ptr_q;
  logic [TW-1:0]     tick_q;
  logic [NCH*DW-1:0] dc_q;
  logic [NCH*DW-1:0] mem [DEPTH];
  logic              pulse, full, tick_end, last, wr_en;
  // sync_q[1] is the synchronised button level, sync_q[2] its previous value
  assign pulse    = sync_q[1] & ~sync_q[2];
  assign full     = cnt_q == (AW+1)'(DEPTH);
  assign tick_end = tick_q == TW'(TICK_DIV - 1);
  assign last     = {1'b0, ptr_q} == cnt_q - (AW+1)'(1);
  assign wr_en    = !Reset_Sw && state_q == RECORD && pulse && !full;
  always_ff @(posedge sysclk) begin
    if (Reset_Sw) state_q <= IDLE;
    else          state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (bus.Storage_Sw)                                        state_d = RECORD;
    else if (state_q == RECORD)                                state_d = IDLE;
    else if (state_q == IDLE && bus.Play_En && cnt_q != '0)    state_d = PLAY;
    else if (state_q != IDLE && !bus.Play_En)                  state_d = IDLE;
    else if (state_q == PLAY && tick_end && last && !bus.Loop_En) state_d = DONE;
  end
  always_comb begin
    bus.DC_Out    = dc_q;
    bus.Rec_Count = cnt_q;
    bus.Full      = full;
    bus.Playing   = state_q == PLAY;
    bus.Done      = state_q == DONE;
  end
  always_ff @(posedge sysclk) begin
    if (wr_en) mem[cnt_q[AW-1:0]] <= bus.Duty_In;
  end
  always_ff @(posedge sysclk) begin
    if (Reset_Sw) begin
      sync_q <= '0;
      cnt_q  <= '0;
      ptr_q  <= '0;
      tick_q <= '0;
      dc_q   <= '0;
    end else begin
      sync_q <= {sync_q[1:0], bus.Bt_Up | bus.Bt_Down | bus.Bt_Left | bus.Bt_Right};
      dc_q   <= state_q == RECORD ? bus.Duty_In :
                state_q == PLAY   ? mem[ptr_q]  :
                state_q == DONE   ? dc_q        : '0;
      if (wr_en) cnt_q <= cnt_q + (AW+1)'(1);
      // holding the pointers cleared in IDLE makes every PLAY entry start at entry 0, tick 0
      if (state_q == IDLE) begin
        ptr_q  <= '0;
        tick_q <= '0;
      end else if (state_q == PLAY) begin
        tick_q <= tick_end ? '0 : tick_q + TW'(1);
        if (tick_end && !last)             ptr_q <= ptr_q + AW'(1);
        else if (tick_end && bus.Loop_En)  ptr_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_duty_seq_recorder.sv
// tb_duty_seq_recorder: table, directed and randomized checks of duty_seq_recorder
module tb_duty_seq_recorder;
  localparam int DW = 6, NCH = 2, DEPTH = 4, AW = 2, TD = 4;
  localparam int S_IDLE = 0, S_REC = 1, S_PLAY = 2, S_DONE = 3;
  typedef struct {
    bit          s, p, l;
    logic [3:0]  b;
    logic [11:0] d;
    int          n;
    logic [11:0] e_dc;
    int          e_cnt;
    logic [2:0]  e_flg;
  } vec_t;
  logic sysclk = 1'b0;
  logic rst_sw = 1'b1;
  int n_cmp = 0, n_bad = 0;
  int m_st, m_ptr, m_tick;
  logic [11:0] m_dc;
  logic [11:0] m_mem[$];
  bit p1, p2, p3;
  vec_t tbl[$];
  duty_seq_recorder_if #(.DW(DW), .NCH(NCH), .AW(AW)) bus();
  duty_seq_recorder #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH), .AW(AW), .TICK_DIV(TD)) dut (
    .sysclk(sysclk), .Reset_Sw(rst_sw), .bus(bus)
  );
  always #5 sysclk = ~sysclk;
  function automatic logic [11:0] dv(int x, int y);
    return {6'(y), 6'(x)};
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic drive(bit s, bit p, bit l, logic [3:0] b, logic [11:0] d);
    bus.Storage_Sw = s;
    bus.Play_En    = p;
    bus.Loop_En    = l;
    {bus.Bt_Right, bus.Bt_Left, bus.Bt_Down, bus.Bt_Up} = b;
    bus.Duty_In    = d;
  endtask
  task automatic model_step();
    bit btn, pulse;
    int ns, sz;
    btn = bus.Bt_Up | bus.Bt_Down | bus.Bt_Left | bus.Bt_Right;
    if (rst_sw) begin
      m_st = S_IDLE; m_mem.delete(); m_ptr = 0; m_tick = 0; m_dc = '0;
      p1 = 0; p2 = 0; p3 = 0;
      return;
    end
    pulse = p2 && !p3;
    p3 = p2; p2 = p1; p1 = btn;
    sz = m_mem.size();
    ns = m_st;
    if (bus.Storage_Sw) ns = S_REC;
    else if (m_st == S_REC) ns = S_IDLE;
    else if (m_st == S_IDLE && bus.Play_En && sz > 0) ns = S_PLAY;
    else if ((m_st == S_PLAY || m_st == S_DONE) && !bus.Play_En) ns = S_IDLE;
    else if (m_st == S_PLAY && m_tick == TD - 1 && m_ptr == sz - 1 && !bus.Loop_En) ns = S_DONE;
    if (m_st == S_REC) begin
      m_dc = bus.Duty_In;
      if (pulse && sz < DEPTH) m_mem.push_back(bus.Duty_In);
    end else if (m_st == S_PLAY) begin
      m_dc = m_mem[m_ptr];
      if (m_tick == TD - 1) begin
        m_tick = 0;
        if (m_ptr == sz - 1) begin
          if (bus.Loop_En) m_ptr = 0;
        end else m_ptr++;
      end else m_tick++;
    end else if (m_st == S_IDLE) m_dc = '0;
    if (m_st == S_IDLE && ns == S_PLAY) begin
      m_ptr = 0;
      m_tick = 0;
    end
    m_st = ns;
  endtask
  task automatic step();
    @(posedge sysclk);
    model_step();
    @(negedge sysclk);
    chk("model_dc", 32'(bus.DC_Out), 32'(m_dc));
    chk("model_cnt", 32'(bus.Rec_Count), 32'(m_mem.size()));
    chk("model_flags", 32'({bus.Full, bus.Playing, bus.Done}),
        32'({m_mem.size() == DEPTH, m_st == S_PLAY, m_st == S_DONE}));
  endtask
  task automatic do_reset();
    rst_sw = 1'b1;
    drive(0, 0, 0, 4'h0, 12'h0);
    step();
    rst_sw = 1'b0;
  endtask
  task automatic press(logic [11:0] d);
    drive(1, 0, 0, 4'h1, d);
    repeat (4) step();
    drive(1, 0, 0, 4'h0, d);
    repeat (3) step();
  endtask
  initial begin
    int n;
    drive(0, 0, 0, 4'h0, 12'h0);
    step();
    step();
    chk("reset_dc", 32'(bus.DC_Out), 32'h0);
    chk("reset_cnt", 32'(bus.Rec_Count), 32'h0);
    chk("reset_flags", 32'({bus.Full, bus.Playing, bus.Done}), 32'h0);
    rst_sw = 1'b0;
    tbl.push_back(vec_t'{1, 0, 0, 4'h0, dv(5, 9),  2,  dv(5, 9),  0, 3'b000});
    tbl.push_back(vec_t'{1, 0, 0, 4'h1, dv(5, 9),  10, dv(5, 9),  1, 3'b000});
    tbl.push_back(vec_t'{1, 0, 0, 4'h0, dv(12, 3), 3,  dv(12, 3), 1, 3'b000});
    tbl.push_back(vec_t'{1, 0, 0, 4'h2, dv(12, 3), 10, dv(12, 3), 2, 3'b000});
    tbl.push_back(vec_t'{1, 0, 0, 4'h0, dv(63, 0), 3,  dv(63, 0), 2, 3'b000});
    tbl.push_back(vec_t'{1, 0, 0, 4'h4, dv(63, 0), 10, dv(63, 0), 3, 3'b000});
    tbl.push_back(vec_t'{1, 0, 0, 4'h0, dv(63, 0), 3,  dv(63, 0), 3, 3'b000});
    tbl.push_back(vec_t'{0, 1, 1, 4'h0, dv(63, 0), 1,  dv(63, 0), 3, 3'b000});
    tbl.push_back(vec_t'{0, 1, 1, 4'h0, dv(63, 0), 1,  12'h0,     3, 3'b010});
    tbl.push_back(vec_t'{0, 1, 1, 4'h0, dv(63, 0), 1,  dv(5, 9),  3, 3'b010});
    tbl.push_back(vec_t'{0, 1, 1, 4'h0, dv(63, 0), 3,  dv(5, 9),  3, 3'b010});
    tbl.push_back(vec_t'{0, 1, 1, 4'h0, dv(63, 0), 1,  dv(12, 3), 3, 3'b010});
    tbl.push_back(vec_t'{0, 1, 1, 4'h0, dv(63, 0), 3,  dv(12, 3), 3, 3'b010});
    tbl.push_back(vec_t'{0, 1, 1, 4'h0, dv(63, 0), 4,  dv(63, 0), 3, 3'b010});
    tbl.push_back(vec_t'{0, 1, 1, 4'h0, dv(63, 0), 1,  dv(5, 9),  3, 3'b010});
    tbl.push_back(vec_t'{0, 0, 1, 4'h0, 12'h0,     1,  dv(5, 9),  3, 3'b000});
    tbl.push_back(vec_t'{0, 0, 1, 4'h0, 12'h0,     1,  12'h0,     3, 3'b000});
    tbl.push_back(vec_t'{0, 1, 0, 4'h0, 12'h0,     1,  12'h0,     3, 3'b010});
    tbl.push_back(vec_t'{0, 1, 0, 4'h0, 12'h0,     11, dv(63, 0), 3, 3'b010});
    tbl.push_back(vec_t'{0, 1, 0, 4'h0, 12'h0,     1,  dv(63, 0), 3, 3'b001});
    tbl.push_back(vec_t'{0, 1, 0, 4'h0, 12'h0,     5,  dv(63, 0), 3, 3'b001});
    tbl.push_back(vec_t'{0, 0, 0, 4'h0, 12'h0,     1,  dv(63, 0), 3, 3'b000});
    tbl.push_back(vec_t'{0, 0, 0, 4'h0, 12'h0,     1,  12'h0,     3, 3'b000});
    foreach (tbl[i]) begin
      drive(tbl[i].s, tbl[i].p, tbl[i].l, tbl[i].b, tbl[i].d);
      repeat (tbl[i].n) step();
      chk($sformatf("tbl%0d_dc", i), 32'(bus.DC_Out), 32'(tbl[i].e_dc));
      chk($sformatf("tbl%0d_cnt", i), 32'(bus.Rec_Count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_flags", i), 32'({bus.Full, bus.Playing, bus.Done}), 32'(tbl[i].e_flg));
    end
    do_reset();
    drive(0, 1, 1, 4'h0, 12'h0);
    repeat (5) step();
    chk("empty_flags", 32'({bus.Full, bus.Playing, bus.Done}), 32'h0);
    chk("empty_dc", 32'(bus.DC_Out), 32'h0);
    do_reset();
    drive(1, 0, 0, 4'h0, 12'h0);
    step();
    for (int v = 1; v <= 6; v++) press(dv(v, v));
    chk("sat_cnt", 32'(bus.Rec_Count), 32'd4);
    chk("sat_full", 32'(bus.Full), 32'd1);
    drive(0, 1, 1, 4'h0, 12'h0);
    step();
    step();
    for (int e = 0; e < 4; e++) begin
      step();
      chk($sformatf("sat_play%0d", e), 32'(bus.DC_Out), 32'(dv(e + 1, e + 1)));
      repeat (3) step();
    end
    do_reset();
    drive(1, 0, 0, 4'h0, 12'h0);
    step();
    press(dv(7, 8));
    press(dv(9, 10));
    drive(0, 1, 1, 4'h0, 12'h0);
    repeat (5) step();
    chk("prio_playing", 32'(bus.Playing), 32'd1);
    drive(1, 1, 1, 4'h0, dv(20, 21));
    step();
    chk("prio_rec_flags", 32'({bus.Full, bus.Playing, bus.Done}), 32'h0);
    step();
    chk("prio_rec_dc", 32'(bus.DC_Out), 32'(dv(20, 21)));
    press(dv(20, 21));
    chk("append_cnt", 32'(bus.Rec_Count), 32'd3);
    drive(0, 1, 1, 4'h0, 12'h0);
    step();
    step();
    step();
    chk("append_e0", 32'(bus.DC_Out), 32'(dv(7, 8)));
    repeat (8) step();
    chk("append_e2", 32'(bus.DC_Out), 32'(dv(20, 21)));
    rst_sw = 1'b1;
    drive(0, 1, 1, 4'h1, dv(11, 11));
    step();
    rst_sw = 1'b0;
    drive(0, 1, 1, 4'h0, dv(11, 11));
    chk("rst_flags", 32'({bus.Full, bus.Playing, bus.Done}), 32'h0);
    chk("rst_cnt", 32'(bus.Rec_Count), 32'h0);
    chk("rst_dc", 32'(bus.DC_Out), 32'h0);
    drive(1, 0, 0, 4'h0, dv(11, 11));
    repeat (6) step();
    chk("rst_press_dropped", 32'(bus.Rec_Count), 32'h0);
    for (int k = 0; k < 400; k++) begin
      n = $urandom_range(1, 10);
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 1) != 0 ? 4'(1 << $urandom_range(0, 3)) : 4'h0, 12'($urandom));
      rst_sw = $urandom_range(0, 39) == 0;
      step();
      rst_sw = 1'b0;
      repeat (n - 1) step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/duty_seq_recorder.md
Name: duty_seq_recorder

Overview:
- Multi-channel duty-cycle record/playback sequencer; the parametrised successor to the two-channel X/Y duty RAM.
- Record mode: one vector of NCH duty values is captured per button press.
- Playback mode: the stored vectors are replayed at a fixed tick rate, looping or one-shot, toward the PWM generators.
- Fixes single-cycle repeat writes, playback past the last written entry, and mass-clear of memory contents.

Parameters:
- DW, 6, bits per duty channel
- NCH, 2, channel count; NCH=2 is X/Y
- DEPTH, 256, stored vectors; power of two
- AW, 8, address width, log2(DEPTH)
- TICK_DIV, 4096, sysclk cycles each entry is held during playback; >=2

Ports:
- sysclk, in, 1, system clock
- Reset_Sw, in, 1, synchronous active-high reset
- Storage_Sw, in, 1, 1 = record mode
- Play_En, in, 1, 1 = request playback (honoured only when Storage_Sw=0)
- Loop_En, in, 1, 1 = wrap to entry 0 at end; 0 = one-shot
- Bt_Up, in, 1, record trigger (asynchronous level)
- Bt_Down, in, 1, record trigger (asynchronous level)
- Bt_Left, in, 1, record trigger (asynchronous level)
- Bt_Right, in, 1, record trigger (asynchronous level)
- Duty_In, in, NCH*DW, live duty vector; channel k = bits [k*DW +: DW]
- DC_Out, out, NCH*DW, registered duty output
- Rec_Count, out, AW+1, number of stored vectors, 0..DEPTH
- Full, out, 1, Rec_Count==DEPTH
- Playing, out, 1, state==PLAY
- Done, out, 1, state==DONE

Behaviour:
- Reset (Reset_Sw=1 at a sysclk edge) sets: state IDLE, Rec_Count 0, Rd_Ptr 0, tick 0, DC_Out 0, sync/edge regs 0.
- Memory contents are not cleared; they are unobservable because Rec_Count=0.
- Reset overrides every other input in that cycle.
- Buttons:
  - OR of the four buttons passes through a 2-FF synchroniser, then a rising-edge detect.
  - One write per press; a held button writes once.
  - Button-to-write latency is 3 cycles (2 sync + 1 edge).
- States: IDLE, RECORD, PLAY, DONE. Transitions are evaluated every cycle in this priority:
  1. Storage_Sw=1 from any state -> RECORD.
  2. RECORD with Storage_Sw=0 -> IDLE.
  3. IDLE with Play_En=1 and Rec_Count>0 -> PLAY; Rd_Ptr<=0, tick<=0.
  4. IDLE with Play_En=1 and Rec_Count=0 -> stays IDLE.
  5. PLAY or DONE with Play_En=0 -> IDLE.
  6. PLAY reaching end with Loop_En=0 -> DONE.
- RECORD:
  - On an edge pulse while in RECORD and not Full: mem[Rec_Count[AW-1:0]] <= Duty_In, Rec_Count <= Rec_Count+1.
  - Full: edge pulses are ignored; Rec_Count saturates at DEPTH.
  - An edge pulse that lands in a non-RECORD cycle is discarded.
  - Re-entering RECORD appends after the existing entries.
  - DC_Out <= Duty_In each cycle (live monitor, 1-cycle latency).
- PLAY:
  - tick counts 0..TICK_DIV-1.
  - When tick==TICK_DIV-1: tick<=0.
    - If Rd_Ptr==Rec_Count-1: Loop_En=1 -> Rd_Ptr<=0; Loop_En=0 -> state DONE, Rd_Ptr held.
    - Otherwise Rd_Ptr<=Rd_Ptr+1.
  - Loop_En is sampled at the end-of-list tick only.
  - DC_Out <= mem[Rd_Ptr] (synchronous read, 1-cycle latency).
  - Entry 0 appears on DC_Out 1 cycle after entering PLAY.
  - Each entry is held exactly TICK_DIV cycles; Rec_Count=1 holds entry 0 indefinitely.
- DONE: DC_Out holds the last entry.
- IDLE: DC_Out <= 0.
- Write and read in the same cycle cannot occur, because the states are exclusive.
- Memory is inferable as block RAM: one write port, one synchronous read port, no reset on the array.

Test Plan:
- All scenarios use DW=6, NCH=2, DEPTH=4, AW=2, TICK_DIV=4.
- Record 3 entries: Storage_Sw=1; press with Duty_In={X=5,Y=9}, then {12,3}, then {63,0}; each press held 10 cycles -> Rec_Count=3 (no extra writes while held); Full=0; DC_Out tracks Duty_In with 1-cycle lag.
- Loop playback: after the record scenario, Storage_Sw=0, Play_En=1, Loop_En=1 -> DC_Out = {5,9} x4 cycles, {12,3} x4, {63,0} x4, then {5,9} again; Playing=1, Done=0.
- One-shot: same data, Loop_En=0 -> after {63,0} is held 4 cycles, Done=1, Playing=0, DC_Out stays {63,0}; Play_En=0 -> IDLE, DC_Out=0 next cycle.
- Full/saturation: record 6 presses with values 1..6 -> Rec_Count=4, Full=1; playback order 1,2,3,4.
- Empty and priority: Rec_Count=0 with Play_En=1 -> stays IDLE, DC_Out=0. During PLAY, raise Storage_Sw -> RECORD next cycle; a new press appends at index Rec_Count.
- Reset mid-operation: Reset_Sw pulsed during PLAY -> next cycle IDLE, Rec_Count=0, DC_Out=0, Playing=0. A press in the same cycle as the reset is not recorded.
